// File: rtl/piso_seq_feeder_pkg.sv
// Shared definitions for the serial feeder of the 111/101 sequence detector:
// FSM state encodings and the default word width.
package piso_seq_feeder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/piso_seq_feeder.sv
// Parallel-in/serial-out feeder: takes WIDTH-bit words over valid/ready and
// streams them one bit per clock, back-to-back words with no idle bubble.
module piso_seq_feeder
  import piso_seq_feeder_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Handshake: a word transfers at a rising edge where din_valid & din_ready.
  // din_ready depends on registers only, so there is no path from din_valid.

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             xfer;
  logic [WIDTH-1:0] shifted;
  logic             out_end;

  assign xfer = din_valid & din_ready;

  // The vacated end is filled with IDLE_BIT; it never reaches sout while valid.
  always_comb begin
    shifted = shreg_q;
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], IDLE_BIT};
    end else begin
      shifted = {IDLE_BIT, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          shreg_d = din;
          cnt_d   = CNT_LAST;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (xfer) begin
          // Reload on the last-bit cycle keeps the stream contiguous.
          shreg_d = din;
          cnt_d   = CNT_LAST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_end    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT);
  assign sout       = sout_valid ? out_end : IDLE_BIT;
  assign din_ready  = (state_q == ST_IDLE) | (cnt_q == '0);

endmodule

// File: tb/tb_piso_seq_feeder.sv
// Directed bench for piso_seq_feeder: vector table for reset, single word,
// back-to-back and stall, plus hand sequences for mid-word reset and LSB-first.
module tb_piso_seq_feeder;

  typedef struct {
    logic       rst;
    logic       dv;
    logic [7:0] din;
    logic       es;
    logic       ev;
    logic       eb;
    logic       er;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, din_valid, din_ready, sout, sout_valid, busy;
  logic [7:0] din;
  logic       l_rst, l_dv, l_ready, l_sout, l_valid, l_busy;
  logic [7:0] l_din;

  int pass_cnt  = 0;
  int total_cnt = 0;
  vec_t vecs[$];
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  piso_seq_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy)
  );

  piso_seq_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(l_rst), .din(l_din), .din_valid(l_dv), .din_ready(l_ready),
    .sout(l_sout), .sout_valid(l_valid), .busy(l_busy)
  );

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
  endtask

  function automatic void add(input logic r, input logic dv, input logic [7:0] d,
                              input logic es, input logic ev, input logic eb, input logic er);
    vec_t v;
    v.rst = r; v.dv = dv; v.din = d; v.es = es; v.ev = ev; v.eb = eb; v.er = er;
    vecs.push_back(v);
  endfunction

  // Accept word w at one edge, then drain it with din_valid=dv_tail / din=d_tail.
  function automatic void add_word(input logic [7:0] w, input logic dv_tail, input logic [7:0] d_tail);
    logic [7:0] ww;
    ww = w;
    add(1'b1, 1'b1, ww, ww[7], 1'b1, 1'b1, 1'b0);
    for (int b = 6; b >= 0; b--) begin
      add(1'b1, dv_tail, d_tail, ww[b], 1'b1, 1'b1, (b == 0));
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; din = 8'h00;
    l_rst = 1'b0; l_dv = 1'b0; l_din = 8'h00;
    @(negedge clk);

    // Reset held two edges with din_valid high: nothing is accepted.
    add(1'b0, 1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 1'b1);
    // Single word E5 -> 1,1,1,0,0,1,0,1 then idle.
    add_word(8'hE5, 1'b0, 8'h00);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Back-to-back E5 then 5C with din_valid held: 16 contiguous bits.
    add_word(8'hE5, 1'b1, 8'h5C);
    add_word(8'h5C, 1'b0, 8'h00);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Five-cycle stall, then 3C starts right after its acceptance.
    for (int s = 0; s < 5; s++) add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    add_word(8'h3C, 1'b0, 8'h00);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; din_valid = vecs[i].dv; din = vecs[i].din;
      cycle();
      check("vec_sout",  i, sout,       vecs[i].es);
      check("vec_valid", i, sout_valid, vecs[i].ev);
      check("vec_busy",  i, busy,       vecs[i].eb);
      check("vec_ready", i, din_ready,  vecs[i].er);
    end

    // Mid-word reset after the 3rd bit of FF: the remaining bits never appear.
    rst = 1'b1; din_valid = 1'b1; din = 8'hFF;
    cycle();
    din_valid = 1'b0;
    check("rst_mid_b0", 0, sout, 1'b1);
    for (int b = 1; b < 3; b++) begin
      cycle();
      check("rst_mid_bit", b, sout, 1'b1);
      check("rst_mid_valid", b, sout_valid, 1'b1);
    end
    rst = 1'b0;
    cycle();
    check("rst_mid_sout",  0, sout,       1'b0);
    check("rst_mid_valid", 0, sout_valid, 1'b0);
    check("rst_mid_ready", 0, din_ready,  1'b1);
    check("rst_mid_busy",  0, busy,       1'b0);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("rst_after_valid", c, sout_valid, 1'b0);
      check("rst_after_sout",  c, sout,       1'b0);
    end

    // LSB-first instance with 07 -> 1,1,1,0,0,0,0,0.
    for (int b = 0; b < 3; b++) exp_q.push_back(1'b1);
    for (int b = 3; b < 8; b++) exp_q.push_back(1'b0);
    l_rst = 1'b1; l_dv = 1'b1; l_din = 8'h07;
    for (int b = 0; b < 8; b++) begin
      cycle();
      l_dv = 1'b0;
      check("lsb_sout",  b, l_sout,  exp_q.pop_front());
      check("lsb_valid", b, l_valid, 1'b1);
    end
    cycle();
    check("lsb_end_valid", 0, l_valid, 1'b0);
    check("lsb_end_ready", 0, l_ready, 1'b1);
    check("lsb_end_busy",  0, l_busy,  1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
